// File: rtl/addr_bus_sequencer_pkg.sv
// addr_bus_sequencer_pkg: shared increment-mode codes, source indices and sequencer state encodings
package addr_bus_sequencer_pkg;

    localparam logic [1:0] INC_NONE = 2'b00;
    localparam logic [1:0] INC_POST = 2'b01;
    localparam logic [1:0] INC_PRE  = 2'b10;

    localparam int PC_A      = 0;
    localparam int ALU_R     = 1;
    localparam int ALUB_DATA = 2;
    localparam int STK_PTR   = 3;

    typedef enum logic [1:0] {
        ABS_IDLE = 2'd0,
        ABS_REQ  = 2'd1,
        ABS_DONE = 2'd2
    } abs_state_t;

endpackage

// File: rtl/addr_bus_sequencer_step_unit.sv
// addr_step_unit: issued and write-back address from source, step and increment mode (modulo 2^ADDR_WIDTH)
module addr_step_unit
    import addr_bus_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [1:0]            step,
    input  logic [1:0]            inc_mode,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step_w;

    assign step_w    = ADDR_WIDTH'(step);
    assign addr      = (inc_mode == INC_PRE) ? src - step_w : src;
    assign next_addr = (inc_mode == INC_POST) ? src + step_w : addr;

endmodule

// File: rtl/addr_bus_sequencer.sv
// addr_bus_sequencer: registered memory address sequencer with pre-dec/post-inc; optional watchdog via ADDR_BUS_TIMEOUT_EN
module addr_bus_sequencer
    import addr_bus_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] SRC_ADDR,
    input  logic [SEL_W-1:0]              ADDR_BUSX,
    input  logic [1:0]                    INC_MODE,
    input  logic [1:0]                    STEP,
    input  logic                          START,
    input  logic                          RD_WR,
    input  logic                          MEM_READY,
    output logic [ADDR_WIDTH-1:0]         ADDR,
    output logic                          MEM_REQ,
    output logic                          MEM_WE,
    output logic [ADDR_WIDTH-1:0]         NEXT_ADDR,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ERR
);

    abs_state_t            state, state_n;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] src, issue, nxt;
    logic                  accept, tmo;

    assign sel    = (int'(ADDR_BUSX) >= NUM_SRC) ? SEL_W'(NUM_SRC - 1) : ADDR_BUSX;
    assign src    = SRC_ADDR[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign accept = START && (state != ABS_REQ);

    addr_step_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_step (
        .src      (src),
        .step     (STEP),
        .inc_mode (INC_MODE),
        .addr     (issue),
        .next_addr(nxt)
    );

    // State register; reset aborts any access without a completion pulse
    always_ff @(posedge CLK)
        state <= RESET ? ABS_IDLE : state_n;

    // Next state: REQ waits for ready (or watchdog), IDLE/DONE accept a new START
    always_comb begin
        state_n = state;
        if (state == ABS_REQ)
            state_n = (MEM_READY || tmo) ? ABS_DONE : ABS_REQ;
        else
            state_n = accept ? ABS_REQ : ABS_IDLE;
    end

    // Capture address, write-back pointer and direction when an access is accepted
    always_ff @(posedge CLK)
        if (RESET) begin
            ADDR      <= '0;
            NEXT_ADDR <= '0;
            MEM_WE    <= 1'b0;
        end else if (accept) begin
            ADDR      <= issue;
            NEXT_ADDR <= nxt;
            MEM_WE    <= RD_WR;
        end

    assign MEM_REQ = (state == ABS_REQ);
    assign BUSY    = (state == ABS_REQ);
    assign DONE    = (state == ABS_DONE);

`ifdef ADDR_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    assign tmo = (state == ABS_REQ) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign ERR = err_q;

    // Watchdog counts REQ cycles from entry; a timeout forces completion and sets a sticky error
    always_ff @(posedge CLK)
        if (RESET) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt <= accept ? '0 : (state == ABS_REQ) ? cnt + 1'b1 : cnt;
            if (tmo && !MEM_READY)
                err_q <= 1'b1;
        end
`else
    assign tmo = 1'b0;
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_addr_bus_sequencer.sv
// tb_addr_bus_sequencer: vector table, hand sequences and randomized accesses against a reference model
module tb_addr_bus_sequencer;

    localparam int AW = 16;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS*AW-1:0] src_addr = '0;
    logic [1:0]    sel = '0, mode = '0, step = '0;
    logic          start = 1'b0, rw = 1'b0, ready = 1'b0;
    logic [AW-1:0] addr, next_addr;
    logic          mem_req, mem_we, busy, done, err;

    int  total = 0;
    int  bad = 0;
    bit  err_exp = 1'b0;

    addr_bus_sequencer #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .TIMEOUT_CYCLES(8)) dut (
        .CLK(clk), .RESET(rst), .SRC_ADDR(src_addr), .ADDR_BUSX(sel), .INC_MODE(mode),
        .STEP(step), .START(start), .RD_WR(rw), .MEM_READY(ready), .ADDR(addr),
        .MEM_REQ(mem_req), .MEM_WE(mem_we), .NEXT_ADDR(next_addr), .BUSY(busy),
        .DONE(done), .ERR(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s0, s1, s2;
        logic [1:0]  sel, mode, step;
        logic        rw;
        int          delay;
        logic [15:0] ea, en;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int s = (v.sel == 0) ? v.s0 : (v.sel == 1) ? v.s1 : v.s2;
        int k = v.step;
        r.ea = (v.mode == 2) ? 16'((s - k) & 'hFFFF) : 16'(s);
        r.en = (v.mode == 1) ? 16'((s + k) & 'hFFFF) : r.ea;
        return r;
    endfunction

    task automatic run(input vec_t v, input bit poke_start, input bit chain);
        src_addr = {v.s2, v.s1, v.s0};
        sel = v.sel; mode = v.mode; step = v.step; rw = v.rw;
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("req_addr", addr, v.ea);
        chk("req_memreq", mem_req, 1);
        chk("req_busy", busy, 1);
        chk("req_we", mem_we, v.rw);
        chk("req_done", done, 0);
        for (int i = 0; i < v.delay; i++) begin
            start = poke_start;
            src_addr = ~src_addr;
            sel = ~sel;
            @(negedge clk);
            chk("hold_addr", addr, v.ea);
            chk("hold_req", mem_req, 1);
            chk("hold_done", done, 0);
        end
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_memreq", mem_req, 0);
        chk("done_busy", busy, 0);
        chk("done_next", next_addr, v.en);
        chk("done_err", err, err_exp);
        if (!chain) begin
            @(negedge clk);
            chk("idle_done", done, 0);
            chk("idle_memreq", mem_req, 0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_next"}, next_addr, 0);
        chk({tag, "_memreq"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        vec_t v;
        int n;
        tbl[0] = '{16'h1234, 16'hAAAA, 16'h5555, 2'd0, 2'd0, 2'd0, 1'b0, 0, 16'h1234, 16'h1234};
        tbl[1] = '{16'h1111, 16'h2222, 16'h0000, 2'd2, 2'd2, 2'd2, 1'b1, 0, 16'hFFFE, 16'hFFFE};
        tbl[2] = '{16'h1111, 16'hFFFF, 16'h3333, 2'd1, 2'd1, 2'd1, 1'b0, 3, 16'hFFFF, 16'h0000};
        tbl[3] = '{16'h1111, 16'h2222, 16'h8000, 2'd3, 2'd1, 2'd3, 1'b1, 1, 16'h8000, 16'h8003};
        tbl[4] = '{16'hFFFF, 16'h2222, 16'h3333, 2'd0, 2'd1, 2'd2, 1'b0, 0, 16'hFFFF, 16'h0001};
        tbl[5] = '{16'h1111, 16'h0010, 16'h3333, 2'd1, 2'd3, 2'd3, 1'b1, 2, 16'h0010, 16'h0010};
        tbl[6] = '{16'h1111, 16'h2222, 16'h0001, 2'd2, 2'd2, 2'd0, 1'b0, 0, 16'h0001, 16'h0001};

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run(tbl[i], i == 2, 1'b0);

        run(tbl[4], 1'b0, 1'b1);
        run(tbl[1], 1'b0, 1'b1);
        run(tbl[3], 1'b0, 1'b0);

        src_addr = {16'h5555, 16'h4444, 16'h7777};
        sel = 2'd0; mode = 2'd1; step = 2'd1; rw = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_req", mem_req, 1);
        rst = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        rst = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk("abort_nodone", done, 0);
        chk("abort_idle", mem_req, 0);

        for (int i = 0; i < 40; i++) begin
            v.s0 = 16'($urandom); v.s1 = 16'($urandom); v.s2 = 16'($urandom);
            v.sel = 2'($urandom_range(0, 3));
            v.mode = 2'($urandom_range(0, 3));
            v.step = 2'($urandom_range(0, 3));
            v.rw = 1'($urandom);
            v.delay = $urandom_range(0, 3);
            v = model(v);
            run(v, 1'($urandom), 1'($urandom));
        end
        @(negedge clk);

`ifdef ADDR_BUS_TIMEOUT_EN
        src_addr = {16'h0300, 16'h0200, 16'h0100};
        sel = 2'd0; mode = 2'd0; step = 2'd0; rw = 1'b0;
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, 8);
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        err_exp = 1'b1;
        repeat (3) @(negedge clk);
        chk("tmo_sticky", err, 1);
        run(tbl[0], 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("tmo_err_clr", err, 0);
        err_exp = 1'b0;
`else
        src_addr = {16'h0300, 16'h0200, 16'h0100};
        sel = 2'd0; mode = 2'd0; step = 2'd0; rw = 1'b0;
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("wait_req", mem_req, 1);
        chk("wait_err", err, 0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("wait_done", done, 1);
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
